// File: rtl/led_sched.sv
// LED bank sequencer: prescaled rotate/blink/bounce patterns, with a host
// override that freezes the engine for HOLD_TICKS ticks and then restores it.
module led_sched #(
   parameter int WIDTH      = 16,
   parameter int PRESCALE   = 1000,
   parameter int HOLD_TICKS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             req_valid,
   input  logic [WIDTH-1:0] req_pattern,
   output logic             req_ready,
   output logic             tick_o,
   output logic             busy,
   output logic [WIDTH-1:0] led
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS - 1);

   localparam logic [1:0] MODE_NONE   = 2'b00;
   localparam logic [1:0] MODE_ROTATE = 2'b01;
   localparam logic [1:0] MODE_BLINK  = 2'b10;
   localparam logic [1:0] MODE_BOUNCE = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, OVR} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] led_q, led_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [1:0]       mode_q, mode_d;
   logic             dirLeft_q, dirLeft_d;
   logic             retRun_q, retRun_d;
   logic             tick;
   logic             accept;

   assign tick      = (state_q != IDLE) && (cnt_q == CNT_MAX);
   assign accept    = req_valid && (state_q != OVR) && !stop_i;
   assign tick_o    = tick;
   assign busy      = (state_q != IDLE);
   assign req_ready = (state_q != OVR);
   assign led       = led_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         led_q     <= '0;
         shadow_q  <= '0;
         cnt_q     <= '0;
         hold_q    <= '0;
         mode_q    <= MODE_NONE;
         dirLeft_q <= 1'b1;
         retRun_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         shadow_q  <= shadow_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         mode_q    <= mode_d;
         dirLeft_q <= dirLeft_d;
         retRun_q  <= retRun_d;
      end
   end

   // Priority on every edge: stop, then an accepted override, then start/tick.
   always_comb begin
      state_d   = state_q;
      led_d     = led_q;
      shadow_d  = shadow_q;
      hold_d    = hold_q;
      mode_d    = mode_q;
      dirLeft_d = dirLeft_q;
      retRun_d  = retRun_q;
      cnt_d     = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);

      if (stop_i) begin
         state_d = IDLE;
         led_d   = '0;
         cnt_d   = '0;
      end else if (accept) begin
         shadow_d = (state_q == RUN) ? led_q : '0;
         retRun_d = (state_q == RUN);
         led_d    = req_pattern;
         hold_d   = '0;
         cnt_d    = '0;
         state_d  = OVR;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && mode_i != MODE_NONE) begin
                  mode_d    = mode_i;
                  led_d     = (mode_i == MODE_BLINK) ? '1 : WIDTH'(1);
                  dirLeft_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  case (mode_q)
                     MODE_ROTATE: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                     MODE_BLINK:  led_d = ~led_q;
                     MODE_BOUNCE: begin
                        // Direction flips on the edge that lands on an end bit.
                        if (dirLeft_q) begin
                           led_d = led_q << 1;
                           if (led_q[WIDTH-2]) dirLeft_d = 1'b0;
                        end else begin
                           led_d = led_q >> 1;
                           if (led_q[1]) dirLeft_d = 1'b1;
                        end
                     end
                     default: led_d = led_q;
                  endcase
               end
            end
            OVR: begin
               if (tick) begin
                  if (hold_q == HOLD_MAX) begin
                     led_d   = shadow_q;
                     state_d = retRun_q ? RUN : IDLE;
                     cnt_d   = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_sched.sv
// Self-checking bench for led_sched: directed scenarios with literal anchors,
// then random traffic, all checked every cycle against a pattern-index model.
module tb_led_sched;

   localparam int W = 16;
   localparam int P = 4;
   localparam int H = 2;

   logic         clk;
   logic         rst_n;
   logic [1:0]   mode;
   logic         start;
   logic         stop;
   logic         reqValid;
   logic [W-1:0] reqPattern;
   logic         reqReady;
   logic         tick;
   logic         busy;
   logic [W-1:0] led;

   int nCompared   = 0;
   int nMismatched = 0;

   // Model: state, ticks advanced in RUN (k), cycles since entry, override countdown.
   int           mState;
   logic [1:0]   mMode;
   int           mK;
   int           mSince;
   int           mRemain;
   int           mRet;
   logic [W-1:0] mOvrPat;

   led_sched #(.WIDTH(W), .PRESCALE(P), .HOLD_TICKS(H)) dut (
      .clk         (clk),
      .rst         (rst_n),
      .mode_i      (mode),
      .start_i     (start),
      .stop_i      (stop),
      .req_valid   (reqValid),
      .req_pattern (reqPattern),
      .req_ready   (reqReady),
      .tick_o      (tick),
      .busy        (busy),
      .led         (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] patFn(input logic [1:0] md, input int k);
      logic [W-1:0] one;
      int p;
      one = 1;
      case (md)
         2'b01: return one << (k % W);
         2'b10: return (k % 2 == 0) ? {W{1'b1}} : {W{1'b0}};
         2'b11: begin
            p = k % (2 * W - 2);
            return one << ((p < W) ? p : (2 * W - 2 - p));
         end
         default: return '0;
      endcase
   endfunction

   function automatic logic [W-1:0] expLed();
      if (mState == 1) return patFn(mMode, mK);
      if (mState == 2) return mOvrPat;
      return '0;
   endfunction

   function automatic logic expTick();
      return (mState != 0) && (mSince % P == P - 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mState = 0; mMode = 2'b00; mK = 0; mSince = 0;
         mRemain = 0; mRet = 0; mOvrPat = '0;
      end else begin
         if (stop) begin
            if (mState != 0) begin
               mState = 0; mSince = 0;
            end
         end else if (reqValid && mState != 2) begin
            mRet = mState; mOvrPat = reqPattern; mState = 2;
            mSince = 0; mRemain = H * P;
         end else if (mState == 0) begin
            if (start && mode != 2'b00) begin
               mMode = mode; mK = 0; mState = 1; mSince = 0;
            end
         end else if (mState == 1) begin
            if (expTick()) mK++;
            mSince++;
         end else begin
            mRemain--;
            mSince++;
            if (mRemain == 0) begin
               mState = mRet; mSince = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("led",       32'(led),      32'(expLed()));
      checkOutput("tick_o",    32'(tick),     32'(expTick()));
      checkOutput("busy",      32'(busy),     32'(mState != 0));
      checkOutput("req_ready", 32'(reqReady), 32'(mState != 2));
   end

   task automatic applyStimulus(input logic st, input logic sp, input logic [1:0] md,
                                input logic rv, input logic [W-1:0] rp);
      start = st; stop = sp; mode = md; reqValid = rv; reqPattern = rp;
      @(posedge clk); #2;
      start = 1'b0; stop = 1'b0; reqValid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
      reqValid = 1'b0; reqPattern = '0;
      idleCycles(3);
      rst_n = 1'b1;
      idleCycles(10);
      checkOutput("reset led",   32'(led),      32'h0);
      checkOutput("reset busy",  32'(busy),     32'h0);
      checkOutput("reset ready", 32'(reqReady), 32'h1);

      // Rotate, wrap, then override mid-run.
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, '0);
      checkOutput("rot seed", 32'(led), 32'h0001);
      idleCycles(4);
      checkOutput("rot tick1", 32'(led), 32'h0002);
      idleCycles(60);
      checkOutput("rot wrap", 32'(led), 32'h0001);
      idleCycles(12);
      checkOutput("rot 0x8", 32'(led), 32'h0008);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 16'hA5A5);
      checkOutput("ovr shown", 32'(led),      32'hA5A5);
      checkOutput("ovr ready", 32'(reqReady), 32'h0);
      idleCycles(7);
      checkOutput("ovr last", 32'(led), 32'hA5A5);
      idleCycles(1);
      checkOutput("ovr restore", 32'(led), 32'h0008);
      idleCycles(3);
      checkOutput("post ovr hold", 32'(led), 32'h0008);
      idleCycles(1);
      checkOutput("post ovr adv", 32'(led), 32'h0010);

      // Bounce across both ends.
      applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, '0);
      checkOutput("bnc seed", 32'(led), 32'h0001);
      idleCycles(60);
      checkOutput("bnc top", 32'(led), 32'h8000);
      idleCycles(4);
      checkOutput("bnc back", 32'(led), 32'h4000);
      idleCycles(56);
      checkOutput("bnc bottom", 32'(led), 32'h0001);
      idleCycles(4);
      checkOutput("bnc no dup", 32'(led), 32'h0002);

      // Blink, then stop racing override and start.
      applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, '0);
      checkOutput("blink seed", 32'(led), 32'hFFFF);
      idleCycles(4);
      checkOutput("blink off", 32'(led), 32'h0000);
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 16'h1234);
      checkOutput("stop led",   32'(led),      32'h0);
      checkOutput("stop busy",  32'(busy),     32'h0);
      checkOutput("stop ready", 32'(reqReady), 32'h1);
      idleCycles(3);

      // Override from IDLE.
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 16'h00FF);
      checkOutput("idle ovr", 32'(led), 32'h00FF);
      idleCycles(7);
      checkOutput("idle ovr last", 32'(led), 32'h00FF);
      idleCycles(1);
      checkOutput("idle ovr end",  32'(led),  32'h0000);
      checkOutput("idle ovr busy", 32'(busy), 32'h0);

      // Asynchronous reset in the middle of an override.
      applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, '0);
      idleCycles(5);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 16'hBEEF);
      idleCycles(2);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async led",   32'(led),      32'h0);
      checkOutput("async ready", 32'(reqReady), 32'h1);
      checkOutput("async busy",  32'(busy),     32'h0);
      idleCycles(2);
      rst_n = 1'b1;
      idleCycles(6);

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            idleCycles(1);
            rst_n = 1'b1;
         end else begin
            applyStimulus(($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 79) == 0),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 39) == 0),
                          W'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
